// File: rtl/lr_sgd_trainer_pkg.sv
// rtl/lr_sgd_trainer_pkg.sv - FSM state type, Q-format constants and saturation helper
package lr_pkg;

  typedef enum logic [2:0] {IDLE, DOT, ERR, UPD, OUT} state_t;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 10;
  localparam int ONE        = 1 << FRAC_W_DEF;

  // Clamp a signed value to the range of a width-bit two's complement number
  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/lr_sgd_trainer_if.sv
// rtl/lr_sgd_trainer_if.sv - sample stream in, prediction/error result out
interface lr_sgd_trainer_if #(
  parameter int N_FEAT = 4,
  parameter int DATA_W = 16
);
  logic                     s_valid;
  logic                     s_ready;
  logic [N_FEAT*DATA_W-1:0] s_x;
  logic [DATA_W-1:0]        s_y;
  logic                     train_en;
  logic                     p_valid;
  logic [DATA_W-1:0]        p_yhat;
  logic [DATA_W-1:0]        p_err;

  modport master (output s_valid, s_x, s_y, train_en,
                  input  s_ready, p_valid, p_yhat, p_err);
  modport slave  (input  s_valid, s_x, s_y, train_en,
                  output s_ready, p_valid, p_yhat, p_err);
endinterface

// File: rtl/lr_sgd_trainer_mac.sv
// rtl/lr_sgd_trainer_mac.sv - single signed multiplier shared by dot-product and weight update
module lr_mac import lr_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10,
  parameter int ACC_W  = 40
) (
  input  logic                     upd_mode,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  addend,
  output logic signed [ACC_W-1:0]  res
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [63:0]         upd_sum;

  assign prod    = a * b;
  // Update mode: addend carries the sign-extended weight, result is the saturated new weight
  assign upd_sum = 64'(addend) + 64'(prod >>> FRAC_W);
  assign res     = upd_mode ? ACC_W'(sat(upd_sum, DATA_W)) : addend + ACC_W'(prod);
endmodule

// File: rtl/lr_sgd_trainer.sv
// rtl/lr_sgd_trainer.sv - fixed-point linear-regression trainer with one time-shared MAC
module lr_sgd_trainer import lr_pkg::*; #(
  parameter int                N_FEAT   = 4,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                FRAC_W   = FRAC_W_DEF,
  parameter int                ACC_W    = 40,
  parameter int                LR_SHIFT = 7,
  parameter logic [DATA_W-1:0] W_INIT   = DATA_W'(ONE / 4),
  localparam int               IDX_W    = $clog2(N_FEAT) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  lr_sgd_trainer_if.slave    bus,
  input  logic               wt_clear,
  input  logic [IDX_W-1:0]   wt_rd_idx,
  output logic [DATA_W-1:0]  wt_rd_data,
  output logic               busy,
  output logic [31:0]        sample_cnt
);
  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic signed [DATA_W-1:0]  x_r [N_FEAT];
  logic signed [DATA_W-1:0]  w   [N_FEAT];
  logic signed [DATA_W-1:0]  y_r, err_r;
  logic                      train_r;
  logic                      ready_en;
  logic signed [ACC_W-1:0]   acc;

  logic signed [DATA_W-1:0]  x_sel, w_sel, step, mac_b, yhat_c, err_c;
  logic signed [ACC_W-1:0]   mac_addend, mac_res;
  logic                      upd_mode, last;

  always_comb begin
    x_sel      = '0;
    w_sel      = '0;
    wt_rd_data = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (idx == IDX_W'(i)) begin
        x_sel = x_r[i];
        w_sel = w[i];
      end
      if (wt_rd_idx == IDX_W'(i)) wt_rd_data = w[i];
    end
    upd_mode   = (state == UPD);
    step       = err_r >>> LR_SHIFT;
    mac_b      = upd_mode ? step : w_sel;
    mac_addend = upd_mode ? ACC_W'(w_sel) : acc;
    last       = (idx == IDX_W'(N_FEAT - 1));
    yhat_c     = DATA_W'(sat(64'(acc >>> FRAC_W), DATA_W));
    err_c      = DATA_W'(sat(64'(y_r) - 64'(yhat_c), DATA_W));
  end

  lr_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
    .upd_mode (upd_mode),
    .a        (x_sel),
    .b        (mac_b),
    .addend   (mac_addend),
    .res      (mac_res)
  );

  // ready_en keeps s_ready low until the first edge after reset release
  assign bus.s_ready = ready_en && (state == IDLE) && !wt_clear;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      y_r         <= '0;
      err_r       <= '0;
      train_r     <= 1'b0;
      ready_en    <= 1'b0;
      bus.p_valid <= 1'b0;
      bus.p_yhat  <= '0;
      bus.p_err   <= '0;
      sample_cnt  <= '0;
      for (int i = 0; i < N_FEAT; i++) begin
        x_r[i] <= '0;
        w[i]   <= W_INIT;
      end
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (wt_clear) begin
            for (int i = 0; i < N_FEAT; i++) w[i] <= W_INIT;
            sample_cnt <= '0;
          end else if (bus.s_valid && bus.s_ready) begin
            for (int i = 0; i < N_FEAT; i++) x_r[i] <= bus.s_x[i*DATA_W +: DATA_W];
            y_r     <= bus.s_y;
            train_r <= bus.train_en;
            acc     <= '0;
            idx     <= '0;
            state   <= DOT;
          end
        end
        DOT: begin
          acc <= mac_res;
          idx <= idx + 1'b1;
          if (last) begin
            idx   <= '0;
            state <= ERR;
          end
        end
        ERR: begin
          bus.p_yhat <= yhat_c;
          bus.p_err  <= err_c;
          err_r      <= err_c;
          if (train_r) begin
            state <= UPD;
          end else begin
            state       <= OUT;
            bus.p_valid <= 1'b1;
          end
        end
        UPD: begin
          for (int i = 0; i < N_FEAT; i++)
            if (idx == IDX_W'(i)) w[i] <= mac_res[DATA_W-1:0];
          idx <= idx + 1'b1;
          if (last) begin
            idx         <= '0;
            state       <= OUT;
            bus.p_valid <= 1'b1;
            if (sample_cnt != '1) sample_cnt <= sample_cnt + 32'd1;
          end
        end
        OUT: begin
          bus.p_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lr_sgd_trainer.sv
// tb/tb_lr_sgd_trainer.sv - randomized self-checking bench with a behavioural SGD model
module tb_lr_sgd_trainer;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wt_clear = 1'b0;
  logic [IW-1:0] wt_rd_idx = '0;
  logic [DW-1:0] wt_rd_data;
  logic          busy;
  logic [31:0]   sample_cnt;

  always #5 clk = ~clk;

  lr_sgd_trainer_if #(.N_FEAT(N), .DATA_W(DW)) bus ();

  lr_sgd_trainer #(.N_FEAT(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .wt_clear   (wt_clear),
    .wt_rd_idx  (wt_rd_idx),
    .wt_rd_data (wt_rd_data),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  int checks = 0, failures = 0, cyc = 0, rel = 0, pv_count = 0;
  longint mw [N];
  longint mcnt = 0;
  typedef struct { int due; longint yh; longint er; bit tr; } exp_t;
  exp_t q[$];
  logic [DW-1:0] cap_yh, cap_er;

  function automatic longint satw(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] h16(longint v);
    logic [63:0] t;
    t = v;
    return t[15:0];
  endfunction

  function automatic logic [N*DW-1:0] pack4(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: one sample = dot product, error, and (if training) a full SGD step
  always @(negedge clk) begin : monitor
    bit busy_exp, ready_exp, pv_exp;
    longint x [N];
    longint dot, yh, er, st;
    if (!rst_n) begin
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_p_valid", bus.p_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sample_cnt", sample_cnt, 0);
      q.delete();
      for (int i = 0; i < N; i++) mw[i] = 256;
      mcnt = 0;
      rel  = 0;
    end else begin
      rel++;
      busy_exp  = (q.size() > 0);
      ready_exp = !busy_exp && !wt_clear && (rel > 1);
      pv_exp    = (q.size() > 0) && (q[0].due == cyc);
      chk("busy", busy, busy_exp);
      if (rel > 1) chk("s_ready", bus.s_ready, ready_exp);
      chk("p_valid", bus.p_valid, pv_exp);
      if (bus.p_valid) pv_count++;
      if (pv_exp) begin
        chk("p_yhat", bus.p_yhat, h16(q[0].yh));
        chk("p_err", bus.p_err, h16(q[0].er));
        if (q[0].tr && mcnt != 64'hFFFF_FFFF) mcnt++;
        void'(q.pop_front());
      end
      chk("sample_cnt", sample_cnt, mcnt);
      if (!busy_exp && wt_clear) begin
        for (int i = 0; i < N; i++) mw[i] = 256;
        mcnt = 0;
      end else if (ready_exp && bus.s_valid) begin
        dot = 0;
        for (int i = 0; i < N; i++) begin
          x[i] = longint'($signed(bus.s_x[i*DW +: DW]));
          dot += x[i] * mw[i];
        end
        yh = satw(dot >>> 10);
        er = satw(longint'($signed(bus.s_y)) - yh);
        if (bus.train_en) begin
          st = er >>> 7;
          for (int i = 0; i < N; i++) mw[i] = satw(mw[i] + ((st * x[i]) >>> 10));
        end
        q.push_back('{cyc + (bus.train_en ? 2*N+2 : N+2), yh, er, bus.train_en});
      end
    end
  end

  task automatic send(input logic [N*DW-1:0] x, input logic [15:0] y, input bit tr, output int acc_cyc);
    @(posedge clk); #1;
    bus.s_x = x; bus.s_y = y; bus.train_en = tr; bus.s_valid = 1'b1;
    acc_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.s_ready) begin acc_cyc = cyc; break; end
    end
    if (acc_cyc < 0) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_result(input int acc_cyc, input int lat, input string name);
    bit got;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.p_valid) begin
        chk({name, "_latency"}, cyc - acc_cyc, lat);
        cap_yh = bus.p_yhat;
        cap_er = bus.p_err;
        got = 1;
        break;
      end
    end
    if (!got) chk({name, "_result_timeout"}, 0, 1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin idle = 1; break; end
    end
    if (!idle) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_weights_model(input string name);
    for (int i = 0; i <= N; i++) begin
      @(posedge clk); #1;
      wt_rd_idx = IW'(i);
      @(negedge clk);
      chk(name, wt_rd_data, (i < N) ? h16(mw[i]) : 16'h0);
    end
  endtask

  task automatic check_weights_lit(input string name, input logic [N*DW-1:0] req);
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      wt_rd_idx = IW'(i);
      @(negedge clk);
      chk(name, wt_rd_data, req[i*DW +: DW]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("s_ready_after_release", bus.s_ready, 1);
  endtask

  function automatic logic [15:0] rnd_val();
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 8192)) - 4096);
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a, a2, pv0;
    logic [N*DW-1:0] xs, xr;
    bus.s_valid = 1'b0; bus.s_x = '0; bus.s_y = '0; bus.train_en = 1'b0;
    xs = pack4(16'h0800, 16'h1000, 16'h0C00, 16'h1800);

    do_reset();
    chk("reset_p_yhat", bus.p_yhat, 0);
    chk("reset_p_err", bus.p_err, 0);
    check_weights_lit("reset_weights", {4{16'h0100}});

    send(xs, 16'h3C00, 1'b1, a);
    wait_result(a, 10, "train");
    chk("train_p_yhat", cap_yh, 16'h0F00);
    chk("train_p_err", cap_er, 16'h2D00);
    wait_idle();
    chk("train_sample_cnt", sample_cnt, 1);
    check_weights_lit("train_weights", pack4(16'h01B4, 16'h0268, 16'h020E, 16'h031C));

    @(posedge clk); #1;
    wt_clear = 1'b1; bus.s_x = xs; bus.s_y = 16'h3C00; bus.train_en = 1'b1; bus.s_valid = 1'b1;
    @(negedge clk);
    chk("clear_s_ready", bus.s_ready, 0);
    @(posedge clk); #1;
    wt_clear = 1'b0; bus.s_valid = 1'b0;
    @(negedge clk);
    chk("clear_busy", busy, 0);
    chk("clear_sample_cnt", sample_cnt, 0);
    check_weights_lit("clear_weights", {4{16'h0100}});
    @(posedge clk); #1;
    wt_rd_idx = IW'(N);
    @(negedge clk);
    chk("rd_idx_out_of_range", wt_rd_data, 0);

    do_reset();
    send(xs, 16'h3C00, 1'b0, a);
    wait_result(a, 6, "predict");
    chk("predict_p_yhat", cap_yh, 16'h0F00);
    chk("predict_p_err", cap_er, 16'h2D00);
    wait_idle();
    chk("predict_sample_cnt", sample_cnt, 0);
    check_weights_lit("predict_weights", {4{16'h0100}});

    send({4{16'h7FFF}}, 16'h8000, 1'b1, a);
    wait_result(a, 10, "sat");
    chk("sat_p_yhat", cap_yh, 16'h7FFF);
    chk("sat_p_err", cap_er, 16'h8000);
    wait_idle();
    check_weights_lit("sat_weights", {4{16'hE100}});

    send(xs, 16'h3C00, 1'b1, a);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    check_weights_lit("reset_mid_upd_weights", {4{16'h0100}});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_p_valid", bus.p_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("s_ready_after_mid_reset", bus.s_ready, 1);

    pv0 = pv_count;
    @(posedge clk); #1;
    bus.s_x = xs; bus.s_y = 16'h3C00; bus.train_en = 1'b1; bus.s_valid = 1'b1;
    a = -1; a2 = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.s_ready) begin a = cyc; break; end
    end
    @(posedge clk); #1;
    bus.s_x = pack4(16'hFC00, 16'h0200, 16'h0000, 16'h0A00); bus.s_y = 16'hF000; bus.train_en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.s_ready) begin a2 = cyc; break; end
    end
    chk("back_to_back_spacing", a2 - a, 11);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    wait_idle();
    chk("back_to_back_pulses", pv_count - pv0, 2);
    check_weights_model("handshake_weights");

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        wt_clear = 1'b1;
        @(posedge clk); #1;
        wt_clear = 1'b0;
      end
      for (int i = 0; i < N; i++) xr[i*DW +: DW] = rnd_val();
      send(xr, rnd_val(), 1'($urandom_range(0, 1)), a);
      wait_idle();
      if (it % 4 == 3) check_weights_model("random_weights");
    end
    check_weights_model("final_weights");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
